// File: rtl/key_bounce_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_bounce_gen
// Bouncing-key source for the active-low push-button path. A clean press or
// release command is turned into a pseudo-random bounce burst on key_n,
// followed by a stable window at the commanded level, ending in a done pulse.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd_press  in   1 = press (key_n goes 0), 0 = release (key_n goes 1)
//   cmd_ready  out  high only while idle; accept = cmd_valid & cmd_ready
//   key_n      out  generated key line, registered, 1 = released
//   busy       out  high while bouncing or settling
//   done       out  one-cycle pulse when the settled window completes
// -----------------------------------------------------------------------------
module key_bounce_gen #(
  parameter int unsigned BOUNCE_CYC = 12,
  parameter int unsigned SETTLE_CYC = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_press,
  output logic cmd_ready,
  output logic key_n,
  output logic busy,
  output logic done
);

  localparam int unsigned MAX_CYC = (BOUNCE_CYC > SETTLE_CYC) ? BOUNCE_CYC : SETTLE_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // An all-zero Fibonacci LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0]   SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE_UP = 2'd0,
    IDLE_DN = 2'd1,
    BOUNCE  = 2'd2,
    SETTLE  = 2'd3
  } state_e;

  // One step of x^16+x^14+x^13+x^11+1, shifted left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          tgt_n_q, tgt_n_d;
  logic          key_n_q, key_n_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    tgt_n_d = tgt_n_q;
    key_n_d = key_n_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    ready_d = 1'b1;

    case (state_q)
      IDLE_UP, IDLE_DN: begin
        if (cmd_valid) begin
          tgt_n_d = ~cmd_press;
          if ((~cmd_press) != key_n_q) begin
            cnt_d   = '0;
            state_d = BOUNCE;
          end else begin
            // Same level again: skip the burst, finish after one settle cycle.
            cnt_d   = SETTLE_LAST;
            state_d = SETTLE;
          end
        end else begin
          state_d = state_q;
        end
      end

      BOUNCE: begin
        if (cnt_q >= BOUNCE_LAST) begin
          key_n_d = tgt_n_q;
          // The edge that lands the target level already counts as the
          // first settled cycle, so done arrives BOUNCE_CYC+SETTLE_CYC
          // edges after the accept edge.
          cnt_d   = CW'(1);
          state_d = SETTLE;
        end else begin
          key_n_d = lfsr_q[0];
          lfsr_d  = lfsr_step(lfsr_q);
          cnt_d   = cnt_q + CW'(1);
        end
      end

      SETTLE: begin
        key_n_d = tgt_n_q;
        if (cnt_q >= SETTLE_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = tgt_n_q ? IDLE_UP : IDLE_DN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE_UP;
        cnt_d   = '0;
        key_n_d = 1'b1;
        tgt_n_d = 1'b1;
      end
    endcase

    // busy/ready are registered from the next state so they line up with it.
    if ((state_d == BOUNCE) || (state_d == SETTLE)) begin
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else begin
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end
  end

  // State, counter, LFSR and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_UP;
      cnt_q   <= '0;
      lfsr_q  <= SEED_EFF;
      tgt_n_q <= 1'b1;
      key_n_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      tgt_n_q <= tgt_n_d;
      key_n_q <= key_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign key_n     = key_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
`timescale 1ns/1ps
// Testbench for key_bounce_gen: a table of vectors for a small-parameter
// instance, directed sequences and randomized commands against a timeline
// model of the default instance, plus a 15-cycle debouncer pairing.
module tb_key_bounce_gen;

  localparam int          B    = 12;
  localparam int          S    = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_press, cmd_ready, key_n, busy, done;
  logic cmd2_valid, cmd2_press, cmd2_ready, key2_n, busy2, done2;

  always #5 clk = ~clk;

  key_bounce_gen #(.BOUNCE_CYC(B), .SETTLE_CYC(S), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_press(cmd_press),
    .cmd_ready(cmd_ready), .key_n(key_n), .busy(busy), .done(done)
  );

  key_bounce_gen #(.BOUNCE_CYC(1), .SETTLE_CYC(2), .LFSR_SEED(16'h0000)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd2_valid), .cmd_press(cmd2_press),
    .cmd_ready(cmd2_ready), .key_n(key2_n), .busy(busy2), .done(done2)
  );

  typedef struct packed {
    logic v; logic p; logic key; logic busy; logic ready; logic done;
  } vec_t;

  typedef struct packed {
    logic key; logic busy; logic ready; logic done;
  } exp_t;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  logic [15:0] m_lfsr = SEED;
  logic m_key = 1'b1;
  int   m_presses = 0, m_releases = 0;
  int   exp_done_cnt = 0, dut_done_cnt = 0;
  int   lo_run = 0, hi_run = 0, deb_rise = 0, deb_fall = 0;
  logic deb_on = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lfsr = SEED; m_key = 1'b1;
    m_presses = 0; m_releases = 0; exp_done_cnt = 0; dut_done_cnt = 0;
    lo_run = 0; hi_run = 0; deb_rise = 0; deb_fall = 0; deb_on = 1'b0;
  endtask

  // Drive one cycle on the default instance and compare with the timeline model.
  task automatic step(input logic v, input logic p);
    exp_t e;
    logic tgt;
    cmd_valid = v;
    cmd_press = p;
    if (exp_q.size() == 0) begin
      if (v) begin
        tgt = ~p;
        exp_q.push_back('{m_key, 1'b1, 1'b0, 1'b0});
        if (tgt != m_key) begin
          for (int k = 0; k < B; k++) begin
            exp_q.push_back('{m_lfsr[0], 1'b1, 1'b0, 1'b0});
            m_lfsr = lfsr_next(m_lfsr);
          end
          for (int k = 1; k < S; k++) exp_q.push_back('{tgt, 1'b1, 1'b0, 1'b0});
          if (p) m_presses++; else m_releases++;
        end
        exp_q.push_back('{tgt, 1'b0, 1'b1, 1'b1});
        m_key = tgt;
      end else begin
        exp_q.push_back('{m_key, 1'b0, 1'b1, 1'b0});
      end
    end
    e = exp_q.pop_front();
    @(negedge clk);
    cyc++;
    chk("key_n", 32'(key_n), 32'(e.key));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
    chk("done", 32'(done), 32'(e.done));
    exp_done_cnt += int'(e.done);
    dut_done_cnt += int'(done);
    if (key_n == 1'b0) begin
      lo_run++; hi_run = 0;
      if (lo_run >= 15 && !deb_on) begin deb_on = 1'b1; deb_rise++; end
    end else begin
      hi_run++; lo_run = 0;
      if (hi_run >= 15 && deb_on) begin deb_on = 1'b0; deb_fall++; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * (B + S) && exp_q.size() != 0; i++) step(1'b0, 1'b0);
  endtask

  vec_t tbl[14];
  int   done_at;

  initial begin
    // Instance with BOUNCE_CYC=1, SETTLE_CYC=2, zero seed (runs as 16'h0001).
    //          v     p     key   busy  ready done
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // press accepted
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // ignored; sample = 1
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // settle at 0
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // done
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // redundant press
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // done
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // release accepted
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // sample = 0
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // settle at 1
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // done
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // redundant release
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // done
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_press = 1'b0;
    cmd2_valid = 1'b0; cmd2_press = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key_n", 32'(key_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst2_key_n", 32'(key2_n), 32'd1);
    chk("rst2_ready", 32'(cmd2_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cmd2_valid = tbl[i].v;
      cmd2_press = tbl[i].p;
      @(negedge clk);
      chk($sformatf("tbl%0d_key_n", i), 32'(key2_n), 32'(tbl[i].key));
      chk($sformatf("tbl%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_ready", i), 32'(cmd2_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_done", i), 32'(done2), 32'(tbl[i].done));
    end
    cmd2_valid = 1'b0;

    // Press with default parameters: done must appear 44 edges after accept.
    step(1'b1, 1'b1);
    done_at = 0;
    for (int c = 1; c <= B + S; c++) begin
      step(1'b0, 1'b0);
      if (done && done_at == 0) done_at = c;
    end
    chk("t2_done_cycle", 32'(done_at), 32'(B + S));
    chk("t2_ready_at_done", 32'(cmd_ready), 32'd1);
    chk("t2_key_settled", 32'(key_n), 32'd0);

    // Release continues the LFSR sequence, then press again.
    step(1'b1, 1'b0);
    drain();
    chk("t3_key_released", 32'(key_n), 32'd1);
    step(1'b1, 1'b1);
    drain();

    // Redundant press while held down.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("t4_done_second_edge", 32'(done), 32'd1);
    step(1'b0, 1'b0);

    // Reset in the middle of a release burst.
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_key_n", 32'(key_n), 32'd1);
    chk("t1_async_ready", 32'(cmd_ready), 32'd1);
    chk("t1_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Fresh burst after reset must restart from the seed.
    step(1'b1, 1'b1);
    drain();

    // Random commands, cmd_valid often held through bursts.
    for (int i = 0; i < 2500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (20) step(1'b0, 1'b0);
    chk("model_saw_presses", 32'(m_presses > 0), 32'd1);
    chk("done_count", 32'(dut_done_cnt), 32'(exp_done_cnt));
    chk("deb_rises", 32'(deb_rise), 32'(m_presses));
    chk("deb_falls", 32'(deb_fall), 32'(m_releases));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
